// File: rtl/hyperbus_device_responder.sv
// Device-side HyperBus responder: decodes the 48-bit CA, applies the CR0 initial latency,
// then serves SRAM bursts (linear or wrapped) or the CR0/ID0 register space at word rate.
module hyperbus_device_responder #(
    parameter int unsigned AddrWidth = 20,
    parameter int unsigned WrapWords = 16,
    parameter logic [15:0] IdValue   = 16'h0C81,
    parameter logic [15:0] Cr0Reset  = 16'h8F1F
) (
    input  logic                 clk_phy_i,
    input  logic                 rst_ni,
    input  logic                 cs_ni,
    input  logic [15:0]          dq_i,
    input  logic [1:0]           rwds_i,
    output logic [15:0]          dq_o,
    output logic                 dq_oe_o,
    output logic [1:0]           rwds_o,
    output logic                 rwds_oe_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [15:0]          mem_wdata_o,
    output logic [1:0]           mem_be_o,
    input  logic [15:0]          mem_rdata_i
);

    localparam logic [AddrWidth-1:0] RegIdAddr  = '0;
    localparam logic [AddrWidth-1:0] RegCr0Addr = AddrWidth'(32'h800);
    localparam logic [AddrWidth-1:0] WrapMask   = AddrWidth'(WrapWords - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CA    = 3'd1,
        LAT   = 3'd2,
        RDATA = 3'd3,
        WDATA = 3'd4,
        REGW  = 3'd5
    } state_e;

    state_e                state_q;
    logic                  ca_second_q;
    logic [31:0]           ca_hi_q;       // CA[47:16]; CA[15:0] arrives live on dq_i
    logic [3:0]            lat_cnt_q;
    logic                  is_read_q;
    logic                  is_reg_q;
    logic                  is_linear_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [15:0]           cr0_q;

    logic                  active;
    logic [2:0]            lat_base;
    logic [3:0]            lat_len;
    logic                  lat_last;
    logic [AddrWidth-1:0]  dec_addr;
    logic [AddrWidth-1:0]  addr_inc;
    logic [AddrWidth-1:0]  addr_next;
    logic [15:0]           reg_rdata;

    assign active   = rst_ni & ~cs_ni;
    assign dec_addr = AddrWidth'({ca_hi_q[28:0], dq_i[2:0]});

    always_comb begin
        lat_base = 3'd6;
        case (cr0_q[7:4])
            4'b1110: lat_base = 3'd3;
            4'b1111: lat_base = 3'd4;
            4'b0000: lat_base = 3'd5;
            4'b0001: lat_base = 3'd6;
            4'b0010: lat_base = 3'd7;
            default: lat_base = 3'd6;
        endcase
    end

    assign lat_len  = cr0_q[3] ? {lat_base, 1'b0} : {1'b0, lat_base};
    assign lat_last = (state_q == LAT) && (lat_cnt_q == lat_len);

    // Wrapped bursts only advance the low log2(WrapWords) bits.
    assign addr_inc  = addr_q + 1'b1;
    assign addr_next = is_linear_q ? addr_inc
                                   : ((addr_q & ~WrapMask) | (addr_inc & WrapMask));

    always_comb begin
        reg_rdata = 16'h0000;
        if (addr_q == RegIdAddr)       reg_rdata = IdValue;
        else if (addr_q == RegCr0Addr) reg_rdata = cr0_q;
    end

    always_ff @(posedge clk_phy_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ca_second_q <= 1'b0;
            ca_hi_q     <= '0;
            lat_cnt_q   <= '0;
            is_read_q   <= 1'b0;
            is_reg_q    <= 1'b0;
            is_linear_q <= 1'b0;
            addr_q      <= '0;
            cr0_q       <= Cr0Reset;
        end else if (cs_ni) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    ca_hi_q[31:16] <= dq_i;
                    ca_second_q    <= 1'b0;
                    state_q        <= CA;
                end
                CA: begin
                    if (!ca_second_q) begin
                        ca_hi_q[15:0] <= dq_i;
                        ca_second_q   <= 1'b1;
                    end else begin
                        is_read_q   <= ca_hi_q[31];
                        is_reg_q    <= ca_hi_q[30];
                        is_linear_q <= ca_hi_q[29];
                        addr_q      <= dec_addr;
                        lat_cnt_q   <= 4'd1;
                        state_q     <= (!ca_hi_q[31] && ca_hi_q[30]) ? REGW : LAT;
                    end
                end
                LAT: begin
                    if (lat_last) begin
                        state_q <= is_read_q ? RDATA : WDATA;
                        // word 0 of a memory read is requested in the last latency cycle
                        if (is_read_q && !is_reg_q) addr_q <= addr_next;
                    end else begin
                        lat_cnt_q <= lat_cnt_q + 1'b1;
                    end
                end
                RDATA: begin
                    if (!is_reg_q) addr_q <= addr_next;
                end
                WDATA: begin
                    addr_q <= addr_next;
                end
                REGW: begin
                    if (addr_q == RegCr0Addr) cr0_q <= dq_i;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Outputs follow state but are gated by chip select so a deselect silences the bus at once.
    always_comb begin
        dq_o        = 16'h0000;
        dq_oe_o     = 1'b0;
        rwds_o      = 2'b00;
        rwds_oe_o   = 1'b0;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = 16'h0000;
        mem_be_o    = 2'b00;
        if (active) begin
            case (state_q)
                IDLE, CA: begin
                    rwds_oe_o = 1'b1;
                    rwds_o    = {2{cr0_q[3]}};
                end
                LAT: begin
                    if (lat_last && is_read_q && !is_reg_q) begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = addr_q;
                    end
                end
                RDATA: begin
                    dq_oe_o   = 1'b1;
                    rwds_oe_o = 1'b1;
                    rwds_o    = 2'b10;
                    dq_o      = is_reg_q ? reg_rdata : mem_rdata_i;
                    if (!is_reg_q) begin
                        mem_req_o  = 1'b1;
                        mem_addr_o = addr_q;
                    end
                end
                WDATA: begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = 1'b1;
                    mem_addr_o  = addr_q;
                    mem_wdata_o = dq_i;
                    mem_be_o    = ~rwds_i;
                end
                default: ;
            endcase
        end
    end

endmodule
